ape_tile_accumulator: RTL and testbench

- Sequential successor to the combinational MPE/APE partial-sum adder.
- Takes one row of LANES lane pairs (MPE value, APE value) per handshake beat and adds each pair.
- Accumulates the sums into a ROWS x LANES on-chip buffer over multiple passes.
- On the final pass, streams finished rows out through a registered valid/ready port to the output writeback stage.

---
 rtl/ape_tile_accumulator.sv | 104 ++++++++++
 tb/tb_ape_tile_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ape_tile_accumulator.sv
// APE tile accumulator: adds MPE/APE lane pairs per row beat,
// accumulates over passes and streams final rows out.
module ape_tile_accumulator #(
  parameter int OUT_BIN_LEN = 16,
  parameter int LANES       = 8,
  parameter int ROWS        = 8,
  parameter bit SATURATE    = 1'b1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [LANES*OUT_BIN_LEN-1:0] mpe_vals,
  input  logic [LANES*OUT_BIN_LEN-1:0] ape_vals,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_BIN_LEN-1:0] out_vals,
  output logic [RW-1:0]          out_row,
  output logic [LANES-1:0]       out_sat,
  output logic                   busy
);

  localparam int W  = OUT_BIN_LEN;
  localparam int SW = W + 2;

  logic [RW-1:0]        row_cnt;
  logic                 mode_first;
  logic                 mode_last;
  logic [LANES*W-1:0]   buf_q [ROWS];
  logic [LANES*W-1:0]   prev;
  logic [LANES*W-1:0]   res;
  logic [LANES-1:0]     ovf;
  logic                 accept;
  logic                 row0;
  logic                 cur_first;
  logic                 cur_last;
  logic [SW-1:0]        s;
  logic [SW-1:0]        acc;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign row0      = (row_cnt == '0);
  assign busy      = !row0;
  // Row-0 beats steer themselves; later rows follow the latched mode.
  assign cur_first = row0 ? in_first : mode_first;
  assign cur_last  = row0 ? in_last  : mode_last;
  assign prev      = buf_q[row_cnt];

  always_comb begin
    res = '0;
    ovf = '0;
    s   = '0;
    acc = '0;
    for (int k = 0; k < LANES; k++) begin
      acc = cur_first ? '0 : SW'(signed'(prev[k*W +: W]));
      s = SW'(signed'(mpe_vals[k*W +: W]))
        + SW'(signed'(ape_vals[k*W +: W]))
        + acc;
      // In range iff the three top bits agree.
      ovf[k] = !((s[SW-1:W-1] == '0) || (s[SW-1:W-1] == '1));
      if (SATURATE && ovf[k])
        res[k*W +: W] = s[SW-1] ? {1'b1, {(W-1){1'b0}}}
                                : {1'b0, {(W-1){1'b1}}};
      else
        res[k*W +: W] = s[W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_cnt    <= '0;
      mode_first <= 1'b1;
      mode_last  <= 1'b0;
      out_valid  <= 1'b0;
      out_vals   <= '0;
      out_row    <= '0;
      out_sat    <= '0;
      for (int r = 0; r < ROWS; r++)
        buf_q[r] <= '0;
    end else begin
      if (accept) begin
        row_cnt <= (row_cnt == RW'(ROWS-1)) ? '0 : row_cnt + 1'b1;
        if (row0) begin
          mode_first <= in_first;
          mode_last  <= in_last;
        end
        if (!cur_last)
          buf_q[row_cnt] <= res;
      end
      if (accept && cur_last) begin
        out_valid <= 1'b1;
        out_vals  <= res;
        out_row   <= row_cnt;
        out_sat   <= ovf;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ape_tile_accumulator.sv
// Directed scoreboard bench for ape_tile_accumulator
// (W=16, LANES=4, ROWS=2; saturating and wrapping instances).
module tb_ape_tile_accumulator;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_first, in_last, out_ready;
  logic [63:0] mpe_vals, ape_vals;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_vals;
  logic [0:0]  out_row;
  logic [3:0]  out_sat;
  logic        in_ready0, out_valid0, busy0;
  logic [63:0] out_vals0;
  logic [0:0]  out_row0;
  logic [3:0]  out_sat0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [0:0]  row;
    logic [63:0] vals;
    logic [63:0] vals0;
    logic [3:0]  sat;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  ape_tile_accumulator #(
    .OUT_BIN_LEN(16), .LANES(4), .ROWS(2), .SATURATE(1'b1)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .mpe_vals(mpe_vals), .ape_vals(ape_vals),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vals(out_vals), .out_row(out_row),
    .out_sat(out_sat), .busy(busy)
  );

  ape_tile_accumulator #(
    .OUT_BIN_LEN(16), .LANES(4), .ROWS(2), .SATURATE(1'b0)
  ) dut0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_first(in_first), .in_last(in_last),
    .mpe_vals(mpe_vals), .ape_vals(ape_vals),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_vals(out_vals0), .out_row(out_row0),
    .out_sat(out_sat0), .busy(busy0)
  );

  function automatic logic [63:0] pk(input int a, b, c, d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [0:0] row, input logic [63:0] v,
                      input logic [63:0] v0, input logic [3:0] sat);
    exp_t e;
    e.row = row; e.vals = v; e.vals0 = v0; e.sat = sat;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clock); #1;
  endtask

  task automatic send(input logic f, l, input logic [63:0] m, a);
    int n;
    in_valid = 1'b1; in_first = f; in_last = l;
    mpe_vals = m; ape_vals = a;
    n = 0;
    while (!in_ready && n < 100) begin
      idle();
      n++;
    end
    chk("send_wait", 64'(n < 100), 64'(1));
    idle();
    in_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_row", 64'(out_row), 64'(e.row));
        chk("out_vals", out_vals, e.vals);
        chk("out_sat", 64'(out_sat), 64'(e.sat));
        chk("wrap_valid", 64'(out_valid0), 64'(1));
        chk("wrap_vals", out_vals0, e.vals0);
        chk("wrap_sat", 64'(out_sat0), 64'(e.sat));
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    mpe_vals = '0; ape_vals = '0; out_ready = 1'b1;
    repeat (3) idle();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_vals", out_vals, 64'(0));
    chk("rst_row", 64'(out_row), 64'(0));
    chk("rst_sat", 64'(out_sat), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    reset = 1'b0;
    idle();

    // single-pass tile
    push(0, pk(11,22,33,44), pk(11,22,33,44), 4'b0);
    send(1, 1, pk(1,2,3,4), pk(10,20,30,40));
    chk("lat1_valid", 64'(out_valid), 64'(1));
    chk("lat1_busy", 64'(busy), 64'(1));
    push(1, pk(0,0,-1,99), pk(0,0,-1,99), 4'b0);
    send(1, 1, pk(-5,0,7,100), pk(5,0,-8,-1));
    idle();
    chk("sp_drained", 64'(out_valid), 64'(0));
    chk("sp_busy", 64'(busy), 64'(0));

    // three-pass accumulate
    for (int p = 0; p < 3; p++) begin
      for (int r = 0; r < 2; r++) begin
        if (p == 2) push(r[0:0], pk(6,6,6,6), pk(6,6,6,6), 4'b0);
        send(p == 0, p == 2, pk(1,1,1,1), pk(1,1,1,1));
        if (p < 2) chk("acc_no_out", 64'(out_valid), 64'(0));
      end
    end
    idle();

    // mode inputs on row 1 are ignored
    send(1, 0, pk(2,2,2,2), '0);
    send(0, 1, pk(2,2,2,2), '0);
    chk("mode_no_last", 64'(out_valid), 64'(0));
    push(0, pk(3,3,3,3), pk(3,3,3,3), 4'b0);
    send(0, 1, pk(1,1,1,1), '0);
    push(1, pk(3,3,3,3), pk(3,3,3,3), 4'b0);
    send(1, 0, pk(1,1,1,1), '0);
    chk("mode_still_last", 64'(out_valid), 64'(1));
    idle();

    // saturation vs wrap
    push(0, pk(32767,-32768,2,0), pk(-32536,32767,2,0), 4'b0011);
    send(1, 1, pk(32000,-32768,1,0), pk(1000,-1,1,0));
    push(1, '0, '0, 4'b0);
    send(1, 1, '0, '0);
    idle();

    // backpressure
    out_ready = 1'b0;
    push(0, pk(3,3,3,3), pk(3,3,3,3), 4'b0);
    send(1, 1, pk(1,1,1,1), pk(2,2,2,2));
    in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
    mpe_vals = pk(4,4,4,4); ape_vals = pk(4,4,4,4);
    push(1, pk(8,8,8,8), pk(8,8,8,8), 4'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_row", 64'(out_row), 64'(0));
      chk("bp_vals", out_vals, pk(3,3,3,3));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_busy", 64'(busy), 64'(1));
    end
    out_ready = 1'b1;
    idle();
    in_valid = 1'b0;
    chk("bp_rel_valid", 64'(out_valid), 64'(1));
    chk("bp_rel_row", 64'(out_row), 64'(1));
    chk("bp_rel_vals", out_vals, pk(8,8,8,8));
    chk("bp_rel_busy", 64'(busy), 64'(0));
    idle();
    chk("bp_drained", 64'(out_valid), 64'(0));

    // reset mid-pass
    send(1, 0, pk(5,5,5,5), pk(5,5,5,5));
    chk("mp_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("mp_rst_busy", 64'(busy), 64'(0));
    chk("mp_rst_valid", 64'(out_valid), 64'(0));
    chk("mp_rst_vals", out_vals, 64'(0));
    chk("mp_rst_row", 64'(out_row), 64'(0));
    chk("mp_rst_sat", 64'(out_sat), 64'(0));
    push(0, '0, '0, 4'b0);
    send(1, 1, '0, '0);
    push(1, '0, '0, 4'b0);
    send(1, 1, '0, '0);
    idle();
    // buffer was cleared, so a bare last pass starts from zero
    push(0, pk(1,1,1,1), pk(1,1,1,1), 4'b0);
    send(0, 1, pk(1,1,1,1), '0);
    push(1, pk(1,1,1,1), pk(1,1,1,1), 4'b0);
    send(0, 1, pk(1,1,1,1), '0);

    repeat (3) idle();
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
